// File: rtl/params_pkg.sv
// Shared sizing for the qubit readout chain.
package params_pkg;
  localparam int unsigned NUM_QUBITS     = 4;
  localparam int unsigned QUBIT_ID_WIDTH = 3;
endpackage

// File: rtl/qubit_occupancy_collector.sv
// Collects per-qubit 3x3 window sums over one frame, then drains one
// occupancy record per qubit in ascending index order.
// Optional macro OCC_STATS_EN: adds popcount of the published occupancy map.
module qubit_occupancy_collector
  import params_pkg::*;
#(
  parameter int unsigned SUM_WIDTH = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid_in,
  input  logic                      i_match_found,
  input  logic [QUBIT_ID_WIDTH-1:0] i_qubit_index,
  input  logic [SUM_WIDTH-1:0]      i_window_sum,
  input  logic                      i_sync_fval,
  input  logic [SUM_WIDTH-1:0]      i_threshold,
  output logic                      o_res_valid,
  input  logic                      i_res_ready,
  output logic [QUBIT_ID_WIDTH-1:0] o_res_qubit,
  output logic [SUM_WIDTH-1:0]      o_res_sum,
  output logic [1:0]                o_res_flags,
  output logic [NUM_QUBITS-1:0]     o_occ_map,
  output logic                      o_frame_done,
  output logic                      o_dup_err,
  output logic                      o_overrun,
  output logic [QUBIT_ID_WIDTH:0]   o_occ_count
);

  localparam int unsigned IDX_W = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1;
  localparam int unsigned CNT_W = QUBIT_ID_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_n;
  logic                  r_fval;
  logic                  r_flush_cnt;
  logic [SUM_WIDTH-1:0]  r_thresh;
  logic [NUM_QUBITS-1:0] r_seen;
  logic [NUM_QUBITS-1:0] w_seen_n;
  logic [NUM_QUBITS-1:0] w_occ_n;
  logic [SUM_WIDTH-1:0]  r_sum   [NUM_QUBITS];
  logic [SUM_WIDTH-1:0]  w_sum_n [NUM_QUBITS];
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_qidx;
  logic [IDX_W-1:0]      w_load_idx;
  logic                  w_fval_rise;
  logic                  w_fval_fall;
  logic                  w_in_range;
  logic                  w_capture;
  logic                  w_dup_n;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_load_rec;
  logic                  w_frame_end;

  assign w_fval_rise = i_sync_fval & ~r_fval;
  assign w_fval_fall = ~i_sync_fval & r_fval;
  assign w_in_range  = 32'(i_qubit_index) < NUM_QUBITS;
  assign w_qidx      = i_qubit_index[IDX_W-1:0];
  assign w_capture   = ((r_state == S_COLLECT) || (r_state == S_FLUSH)) &&
                       i_valid_in && i_match_found && w_in_range;
  assign w_accept    = o_res_valid & i_res_ready;
  assign w_last      = (r_idx == IDX_W'(NUM_QUBITS - 1));
  assign w_frame_end = (r_state == S_DRAIN) && w_accept && w_last;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_n;
  end

  // Next-state: FLUSH holds two cycles to catch matches still in the upstream pipe
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:    if (w_fval_rise) w_state_n = S_COLLECT;
      S_COLLECT: if (w_fval_fall) w_state_n = S_FLUSH;
      S_FLUSH:   if (r_flush_cnt) w_state_n = S_DRAIN;
      S_DRAIN:   if (w_accept && w_last) w_state_n = S_IDLE;
      default:   w_state_n = S_IDLE;
    endcase
  end

  // Next per-qubit store contents; first match of a frame wins
  always_comb begin
    w_seen_n = r_seen;
    w_sum_n  = r_sum;
    w_dup_n  = 1'b0;
    if ((r_state == S_IDLE) && w_fval_rise) begin
      w_seen_n = '0;
    end else if (w_capture) begin
      if (r_seen[w_qidx]) begin
        w_dup_n = 1'b1;
      end else begin
        w_seen_n[w_qidx] = 1'b1;
        w_sum_n[w_qidx]  = i_window_sum;
      end
    end
    for (int unsigned i = 0; i < NUM_QUBITS; i++) begin
      w_occ_n[i] = w_seen_n[i] && (w_sum_n[i] >= r_thresh);
    end
  end

  // Record load: index 0 on leaving FLUSH (bypassing a last-cycle capture), then next on accept
  always_comb begin
    w_load_rec = 1'b0;
    w_load_idx = '0;
    if ((r_state == S_FLUSH) && r_flush_cnt) begin
      w_load_rec = 1'b1;
    end else if ((r_state == S_DRAIN) && w_accept && !w_last) begin
      w_load_rec = 1'b1;
      w_load_idx = r_idx + IDX_W'(1);
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fval       <= 1'b0;
      r_flush_cnt  <= 1'b0;
      r_thresh     <= '0;
      r_seen       <= '0;
      r_idx        <= '0;
      for (int unsigned i = 0; i < NUM_QUBITS; i++) r_sum[i] <= '0;
      o_res_valid  <= 1'b0;
      o_res_qubit  <= '0;
      o_res_sum    <= '0;
      o_res_flags  <= 2'b00;
      o_occ_map    <= '0;
      o_frame_done <= 1'b0;
      o_dup_err    <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      r_fval       <= i_sync_fval;
      r_seen       <= w_seen_n;
      r_sum        <= w_sum_n;
      o_dup_err    <= w_dup_n;
      o_frame_done <= 1'b0;
      r_flush_cnt  <= (r_state == S_FLUSH) ? ~r_flush_cnt : 1'b0;
      if ((r_state == S_IDLE) && w_fval_rise) r_thresh <= i_threshold;
      if (w_fval_rise && ((r_state == S_FLUSH) || (r_state == S_DRAIN))) o_overrun <= 1'b1;
      if (w_load_rec) begin
        r_idx       <= w_load_idx;
        o_res_valid <= 1'b1;
        o_res_qubit <= QUBIT_ID_WIDTH'(w_load_idx);
        o_res_sum   <= w_seen_n[w_load_idx] ? w_sum_n[w_load_idx] : '0;
        o_res_flags <= {w_seen_n[w_load_idx], w_occ_n[w_load_idx]};
      end else if (w_frame_end) begin
        r_idx        <= '0;
        o_res_valid  <= 1'b0;
        o_res_qubit  <= '0;
        o_res_sum    <= '0;
        o_res_flags  <= 2'b00;
        o_occ_map    <= w_occ_n;
        o_frame_done <= 1'b1;
      end
    end
  end

`ifdef OCC_STATS_EN
  logic [CNT_W-1:0] w_pop;

  // Population count of the map about to be published
  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < NUM_QUBITS; i++) w_pop = w_pop + CNT_W'(w_occ_n[i]);
  end

  // Occupied-qubit count, updated together with the map
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)         o_occ_count <= '0;
    else if (w_frame_end) o_occ_count <= w_pop;
  end
`else
  assign o_occ_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_qubit_occupancy_collector.sv
// Directed bench for qubit_occupancy_collector (NUM_QUBITS=4, threshold 100).
module tb_qubit_occupancy_collector;
  import params_pkg::*;

  localparam int unsigned SW = 12;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      valid_in;
  logic                      match_found;
  logic [QUBIT_ID_WIDTH-1:0] qubit_index;
  logic [SW-1:0]             window_sum;
  logic                      fval;
  logic [SW-1:0]             threshold;
  logic                      res_valid;
  logic                      res_ready;
  logic [QUBIT_ID_WIDTH-1:0] res_qubit;
  logic [SW-1:0]             res_sum;
  logic [1:0]                res_flags;
  logic [NUM_QUBITS-1:0]     occ_map;
  logic                      frame_done;
  logic                      dup_err;
  logic                      overrun;
  logic [QUBIT_ID_WIDTH:0]   occ_count;

  int checks = 0;
  int errors = 0;

  qubit_occupancy_collector #(.SUM_WIDTH(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_in(valid_in), .i_match_found(match_found),
    .i_qubit_index(qubit_index), .i_window_sum(window_sum), .i_sync_fval(fval),
    .i_threshold(threshold), .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_qubit(res_qubit), .o_res_sum(res_sum), .o_res_flags(res_flags),
    .o_occ_map(occ_map), .o_frame_done(frame_done), .o_dup_err(dup_err),
    .o_overrun(overrun), .o_occ_count(occ_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int q, input int s, input int f);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_qubit"}, 32'(res_qubit), 32'(q));
    chk({tag, "_sum"},   32'(res_sum),   32'(s));
    chk({tag, "_flags"}, 32'(res_flags), 32'(f));
  endtask

  task automatic match(input int q, input int s);
    valid_in    = 1'b1;
    match_found = 1'b1;
    qubit_index = QUBIT_ID_WIDTH'(q);
    window_sum  = SW'(s);
    step();
    valid_in    = 1'b0;
    match_found = 1'b0;
  endtask

  function automatic logic [31:0] exp_count(input int n);
`ifdef OCC_STATS_EN
    return 32'(n);
`else
    return 32'(n) & 32'd0;
`endif
  endfunction

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; match_found = 1'b0; qubit_index = '0;
    window_sum = '0; fval = 1'b0; threshold = SW'(100); res_ready = 1'b1;
    step(); step();
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_map", 32'(occ_map), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_count", 32'(occ_count), 0);
    rst_n = 1'b1;
    step();

    // Frame 1: basic occupancy, threshold boundary below, out-of-range id
    fval = 1'b1; step();
    match(0, 150);
    match(2, 99);
    match(5, 300);
    fval = 1'b0; step();
    chk("lat_e0_valid", 32'(res_valid), 0);
    step();
    chk("lat_e1_valid", 32'(res_valid), 0);
    step();
    chk_rec("f1_r0", 0, 150, 3); step();
    chk_rec("f1_r1", 1, 0, 0);   step();
    chk_rec("f1_r2", 2, 99, 2);  step();
    chk_rec("f1_r3", 3, 0, 0);
    chk("f1_done_early", 32'(frame_done), 0);
    step();
    chk("f1_valid_end", 32'(res_valid), 0);
    chk("f1_done", 32'(frame_done), 1);
    chk("f1_map", 32'(occ_map), 32'b0001);
    chk("f1_count", 32'(occ_count), exp_count(1));
    step();
    chk("f1_done_pulse", 32'(frame_done), 0);

    // Frame 2: duplicate, capture in FLUSH, back-pressure on record 1
    fval = 1'b1; step();
    match(1, 200);
    chk("f2_no_dup", 32'(dup_err), 0);
    match(1, 50);
    chk("f2_dup", 32'(dup_err), 1);
    step();
    chk("f2_dup_pulse", 32'(dup_err), 0);
    fval = 1'b0; step();
    match(3, 120);
    step();
    chk_rec("f2_r0", 0, 0, 0);
    step();
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_rec("f2_hold", 1, 200, 3);
      chk("f2_hold_done", 32'(frame_done), 0);
      step();
    end
    chk_rec("f2_r1", 1, 200, 3);
    res_ready = 1'b1;
    step();
    chk_rec("f2_r2", 2, 0, 0);   step();
    chk_rec("f2_r3", 3, 120, 3);
    chk("f2_done_early", 32'(frame_done), 0);
    step();
    chk("f2_done", 32'(frame_done), 1);
    chk("f2_map", 32'(occ_map), 32'b1010);
    chk("f2_count", 32'(occ_count), exp_count(2));

    // Frame 3 with an overrunning frame starting during DRAIN
    fval = 1'b1; step();
    match(2, 500);
    fval = 1'b0; step(); step(); step();
    res_ready = 1'b0;
    chk_rec("f3_r0_wait", 0, 0, 0);
    chk("f3_no_overrun", 32'(overrun), 0);
    fval = 1'b1; step();
    chk("f3_overrun", 32'(overrun), 1);
    match(0, 400);
    res_ready = 1'b1;
    chk_rec("f3_r0", 0, 0, 0);   step();
    chk_rec("f3_r1", 1, 0, 0);   step();
    chk_rec("f3_r2", 2, 500, 3); step();
    chk_rec("f3_r3", 3, 0, 0);   step();
    chk("f3_done", 32'(frame_done), 1);
    chk("f3_map", 32'(occ_map), 32'b0100);
    match(1, 300);
    step(); step();
    chk("skip_idle_valid", 32'(res_valid), 0);
    fval = 1'b0; step(); step(); step(); step();
    chk("skip_no_valid", 32'(res_valid), 0);

    // Frame 4: normal after overrun, sum equal to threshold counts as occupied
    fval = 1'b1; step();
    match(3, 100);
    fval = 1'b0; step(); step(); step();
    chk_rec("f4_r0", 0, 0, 0);   step();
    chk_rec("f4_r1", 1, 0, 0);   step();
    chk_rec("f4_r2", 2, 0, 0);   step();
    chk_rec("f4_r3", 3, 100, 3); step();
    chk("f4_done", 32'(frame_done), 1);
    chk("f4_map", 32'(occ_map), 32'b1000);
    chk("f4_count", 32'(occ_count), exp_count(1));
    chk("f4_overrun_sticky", 32'(overrun), 1);
    step();

    // Frame 5: reset in DRAIN after record 1 accepted
    fval = 1'b1; step();
    match(0, 150);
    fval = 1'b0; step(); step(); step();
    chk_rec("f5_r0", 0, 150, 3); step();
    chk_rec("f5_r1", 1, 0, 0);   step();
    rst_n = 1'b0; step();
    chk("f5_rst_valid", 32'(res_valid), 0);
    chk("f5_rst_qubit", 32'(res_qubit), 0);
    chk("f5_rst_sum", 32'(res_sum), 0);
    chk("f5_rst_flags", 32'(res_flags), 0);
    chk("f5_rst_map", 32'(occ_map), 0);
    chk("f5_rst_count", 32'(occ_count), 0);
    chk("f5_rst_overrun", 32'(overrun), 0);
    chk("f5_rst_done", 32'(frame_done), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("f5_post_done", 32'(frame_done), 0);
      chk("f5_post_valid", 32'(res_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
